// File: rtl/dut_vector_sequencer.sv
// Vector sequencer: pops stimulus vectors, holds each on the DUT pins for a fixed count or until a trigger/timeout,
// then writes one result record per vector. Define DUT_SEQ_EDGE_TRIG_EN to make mode 11 a rising-edge trigger.
module dut_vector_sequencer #(
  parameter int unsigned STF_WIDTH   = 24,
  parameter int unsigned RTF_WIDTH   = 24,
  parameter int unsigned CYCLE_RANGE = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [STF_WIDTH+CYCLE_RANGE+1:0]   stim_data,
  input  logic                               stim_empty,
  output logic                               stim_rdreq,
  input  logic                               cfg_valid,
  input  logic                               cfg_addr,
  input  logic [RTF_WIDTH-1:0]               cfg_data,
  output logic [RTF_WIDTH+CYCLE_RANGE+1:0]   res_data,
  output logic                               res_wrreq,
  input  logic                               res_full,
  output logic [STF_WIDTH-1:0]               mosi_data,
  input  logic [RTF_WIDTH-1:0]               miso_data,
  output logic                               busy
);

  localparam int unsigned STIM_W = STF_WIDTH + CYCLE_RANGE + 2;
  localparam int unsigned RES_W  = RTF_WIDTH + CYCLE_RANGE + 2;

  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_ALL   = 2'b01;
  localparam logic [1:0] MODE_ANY   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CYCLE_RANGE-1:0] cycles_q, cycles_d;
  logic [1:0]             mode_q, mode_d;
  logic [CYCLE_RANGE-1:0] cnt_q, cnt_d;
  logic [RTF_WIDTH-1:0]   miso_q;
  logic [RTF_WIDTH-1:0]   mask_q, value_q;
  logic [STF_WIDTH-1:0]   mosi_q, mosi_d;
  logic [RES_W-1:0]       res_q, res_d;
  logic                   wr_q, wr_d;
  logic                   busy_q, busy_d;
`ifdef DUT_SEQ_EDGE_TRIG_EN
  logic [RTF_WIDTH-1:0]   prev_q, prev_d;
`endif

  logic [STF_WIDTH-1:0]   stim_vec;
  logic [CYCLE_RANGE-1:0] stim_cyc;
  logic [1:0]             stim_mode;
  logic [CYCLE_RANGE-1:0] fixed_end;
  logic                   hit;

  assign stim_vec  = stim_data[STIM_W-1 -: STF_WIDTH];
  assign stim_cyc  = stim_data[CYCLE_RANGE+1:2];
  assign stim_mode = stim_data[1:0];

  // FIXED holds max(cycles,1) RUN cycles, so its last counter value is max(cycles,1)-1
  assign fixed_end = (cycles_q == '0) ? '0 : CYCLE_RANGE'(cycles_q - 1'b1);

  // Trigger evaluation against the registered DUT response
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      MODE_FIXED: hit = 1'b0;
      MODE_ALL:   hit = ((miso_q & mask_q) == (value_q & mask_q));
      MODE_ANY:   hit = |(miso_q & mask_q);
`ifdef DUT_SEQ_EDGE_TRIG_EN
      default:    hit = |(miso_q & ~prev_q & mask_q);
`else
      default:    hit = ((miso_q & mask_q) == (value_q & mask_q));
`endif
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    mosi_d     = mosi_q;
    res_d      = res_q;
    wr_d       = 1'b0;
    stim_rdreq = 1'b0;
`ifdef DUT_SEQ_EDGE_TRIG_EN
    prev_d     = prev_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!stim_empty && !reset) begin
          stim_rdreq = 1'b1;
          mosi_d     = stim_vec;
          cycles_d   = stim_cyc;
          mode_d     = stim_mode;
          cnt_d      = '0;
`ifdef DUT_SEQ_EDGE_TRIG_EN
          prev_d     = miso_q;
`endif
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
`ifdef DUT_SEQ_EDGE_TRIG_EN
        prev_d = miso_q;
`endif
        if (mode_q == MODE_FIXED) begin
          if (cnt_q == fixed_end) begin
            res_d   = {miso_q, cnt_q, 1'b0, 1'b0};
            state_d = S_WRITE;
          end else begin
            cnt_d = CYCLE_RANGE'(cnt_q + 1'b1);
          end
        end else if (hit) begin
          res_d   = {miso_q, cnt_q, 1'b0, 1'b1};
          state_d = S_WRITE;
        end else if (cnt_q == cycles_q) begin
          res_d   = {miso_q, cnt_q, 1'b1, 1'b0};
          state_d = S_WRITE;
        end else begin
          cnt_d = CYCLE_RANGE'(cnt_q + 1'b1);
        end
      end
      S_WRITE: begin
        if (!res_full) begin
          wr_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cycles_q <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
      miso_q   <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      mosi_q   <= '0;
      res_q    <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DUT_SEQ_EDGE_TRIG_EN
      prev_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      miso_q   <= miso_data;
      mosi_q   <= mosi_d;
      res_q    <= res_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
`ifdef DUT_SEQ_EDGE_TRIG_EN
      prev_q   <= prev_d;
`endif
      if (cfg_valid && !cfg_addr) mask_q  <= cfg_data;
      if (cfg_valid &&  cfg_addr) value_q <= cfg_data;
    end
  end

  assign mosi_data = mosi_q;
  assign res_data  = res_q;
  assign res_wrreq = wr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Randomised bench for dut_vector_sequencer: each written record is predicted per vector from the
// recorded history of the DUT response and result-FIFO full flag.
module tb_dut_vector_sequencer;

  localparam int unsigned SW   = 24;
  localparam int unsigned RW   = 24;
  localparam int unsigned CR   = 8;
  localparam int unsigned MAXC = 8192;

  logic              clock = 1'b0;
  logic              reset;
  logic [SW+CR+1:0]  stim_data;
  logic              stim_empty;
  logic              stim_rdreq;
  logic              cfg_valid;
  logic              cfg_addr;
  logic [RW-1:0]     cfg_data;
  logic [RW+CR+1:0]  res_data;
  logic              res_wrreq;
  logic              res_full;
  logic [SW-1:0]     mosi_data;
  logic [RW-1:0]     miso_data;
  logic              busy;

  dut_vector_sequencer #(.STF_WIDTH(SW), .RTF_WIDTH(RW), .CYCLE_RANGE(CR)) u_dut (
    .clock(clock), .reset(reset),
    .stim_data(stim_data), .stim_empty(stim_empty), .stim_rdreq(stim_rdreq),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .res_data(res_data), .res_wrreq(res_wrreq), .res_full(res_full),
    .mosi_data(mosi_data), .miso_data(miso_data), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          f;
    logic [23:0] data;
    logic [7:0]  cyc;
    logic [1:0]  mode;
    logic [23:0] mask;
    logic [23:0] value;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nwr    = 0;
  int nfetch = 0;

  logic [33:0] sfifo [$];
  vec_t        fq [$];
  logic [23:0] mq [MAXC];
  bit          fullh [MAXC];
  logic [23:0] mask_m, value_m;
  bit          rand_miso, rand_full, pend_busy;

  logic [33:0] last_rec;
  int          last_w, last_f;
  logic [33:0] s_res;
  logic [23:0] s_mosi;
  logic        s_wr, s_busy, s_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic hit(input logic [1:0] mode, input logic [23:0] q, input logic [23:0] p,
                               input logic [23:0] mask, input logic [23:0] val);
    case (mode)
      2'b01:   return (q & mask) == (val & mask);
      2'b10:   return (q & mask) != 0;
`ifdef DUT_SEQ_EDGE_TRIG_EN
      2'b11:   return (q & ~p & mask) != 0;
`else
      2'b11:   return (q & mask) == (val & mask);
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Expected record and write-strobe cycle for a vector fetched in cycle v.f
  task automatic predict(input vec_t v, output logic [33:0] rec, output int wcyc);
    int j_end;
    logic m, t;
    int c;
    m = 1'b0;
    t = 1'b0;
    j_end = 0;
    if (v.mode == 2'b00) begin
      j_end = (v.cyc == 0) ? 0 : int'(v.cyc) - 1;
    end else begin
      for (int j = 0; j <= int'(v.cyc); j++) begin
        if (hit(v.mode, mq[v.f+1+j], mq[v.f+j], v.mask, v.value)) begin
          j_end = j; m = 1'b1; break;
        end
        if (j == int'(v.cyc)) begin
          j_end = j; t = 1'b1;
        end
      end
    end
    rec = {mq[v.f+1+j_end], 8'(j_end), t, m};
    c = v.f + j_end + 2;
    while (c < MAXC - 1 && fullh[c]) c++;
    wcyc = c + 1;
  endtask

  task automatic drive_stim();
    stim_empty = (sfifo.size() == 0);
    stim_data  = (sfifo.size() != 0) ? sfifo[0] : '0;
  endtask

  task automatic push(input logic [23:0] d, input logic [7:0] c, input logic [1:0] m);
    sfifo.push_back({d, c, m});
    drive_stim();
  endtask

  // One clock: sample and check at the falling edge, drive inputs just after the rising edge
  task automatic step();
    vec_t v;
    logic [33:0] er;
    int ew;
    bit pop;
    pop = 1'b0;
    @(negedge clock);
    if (cyc >= int'(MAXC) - 2) begin
      $display("FAIL cycle_budget got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (res_wrreq) begin
      nwr++;
      if (fq.size() == 0) check("spurious_write", 1, 0);
      else begin
        v = fq.pop_front();
        predict(v, er, ew);
        check("record", 64'(res_data), 64'(er));
        check("write_cycle", 64'(cyc), 64'(ew));
        check("mosi_hold", 64'(mosi_data), 64'(v.data));
        last_rec = res_data;
        last_w   = cyc;
        last_f   = v.f;
      end
    end
    if (pend_busy) check("busy_run", 64'(busy), 1);
    pend_busy = 1'b0;
    if (cfg_valid && !reset) begin
      if (cfg_addr) value_m = cfg_data;
      else          mask_m  = cfg_data;
    end
    if (stim_rdreq) begin
      check("fetch_order", 64'(fq.size()), 0);
      v.f = cyc; v.data = sfifo[0][33:10]; v.cyc = sfifo[0][9:2]; v.mode = sfifo[0][1:0];
      v.mask = mask_m; v.value = value_m;
      fq.push_back(v);
      nfetch++;
      pend_busy = 1'b1;
      pop = 1'b1;
    end
    if (reset) begin
      fq.delete();
      mask_m = '0; value_m = '0; pend_busy = 1'b0;
    end
    mq[cyc+1]  = reset ? 24'h0 : miso_data;
    fullh[cyc] = res_full;
    s_res = res_data; s_mosi = mosi_data; s_wr = res_wrreq; s_busy = busy; s_rd = stim_rdreq;
    @(posedge clock);
    #1;
    if (pop && sfifo.size() != 0) void'(sfifo.pop_front());
    drive_stim();
    if (rand_miso) miso_data = 24'($urandom) & (($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'h00000F);
    if (rand_full) res_full = ($urandom_range(0, 3) == 0);
    cyc++;
  endtask

  task automatic cfg_write(input logic a, input logic [23:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (fq.size() == 0 && sfifo.size() == 0 && !s_busy) return;
    end
    check("drain_timeout", 0, 1);
  endtask

  initial begin
    int base;
    logic [33:0] hold;
    for (int i = 0; i < int'(MAXC); i++) begin mq[i] = '0; fullh[i] = 1'b0; end
    reset = 1'b1; cfg_valid = 1'b0; cfg_addr = 1'b0; cfg_data = '0;
    res_full = 1'b0; miso_data = '0; mask_m = '0; value_m = '0;
    rand_miso = 1'b0; rand_full = 1'b0; pend_busy = 1'b0;
    last_rec = '0; last_w = 0; last_f = 0;
    drive_stim();
    @(posedge clock); #1;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_mosi", 64'(s_mosi), 0);
    check("rst_res", 64'(s_res), 0);
    check("rst_wr", 64'(s_wr), 0);
    check("rst_busy", 64'(s_busy), 0);
    check("rst_rd", 64'(s_rd), 0);

    // FIXED vector, random DUT response
    rand_miso = 1'b1;
    push(24'hA5A5A5, 8'd3, 2'b00);
    wait_idle(40);
    check("fix_latency", 64'(last_w - last_f), 5);
    check("fix_count", 64'(last_rec[9:2]), 2);
    check("fix_flags", 64'(last_rec[1:0]), 0);

    // TRIG_ALL: response reaches the value after 4 cycles
    rand_miso = 1'b0; miso_data = '0;
    cfg_write(1'b0, 24'h00000F);
    cfg_write(1'b1, 24'h000005);
    push(24'h123456, 8'd10, 2'b01);
    for (int i = 0; i < 4; i++) step();
    miso_data = 24'h000005;
    wait_idle(40);
    check("all_flags", 64'(last_rec[1:0]), 2'b01);

    // TRIG_ANY timeout, then the single-check case
    miso_data = '0;
    cfg_write(1'b0, 24'h000100);
    push(24'h0F0F0F, 8'd6, 2'b10);
    wait_idle(40);
    check("any_to_flags", 64'(last_rec[1:0]), 2'b10);
    check("any_to_count", 64'(last_rec[9:2]), 6);
    push(24'h0F0F0E, 8'd0, 2'b10);
    wait_idle(40);
    check("any_single_flags", 64'(last_rec[1:0]), 2'b10);
    check("any_single_count", 64'(last_rec[9:2]), 0);

    // Result FIFO full while the record waits
    rand_miso = 1'b1;
    res_full = 1'b1;
    push(24'h777777, 8'd2, 2'b00);
    for (int i = 0; i < 4; i++) step();
    push(24'h888888, 8'd1, 2'b00);
    hold = s_res;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_no_write", 64'(s_wr), 0);
      check("bp_res_stable", 64'(s_res), 64'(hold));
    end
    res_full = 1'b0;
    wait_idle(40);

    // Back-to-back vectors with a reset in the second one's RUN phase
    base = nwr;
    push(24'h111111, 8'd4, 2'b00);
    push(24'h222222, 8'd4, 2'b00);
    push(24'h333333, 8'd4, 2'b00);
    begin
      int tgt;
      tgt = nfetch + 2;
      for (int i = 0; i < 40 && nfetch < tgt; i++) step();
      check("b2b_second_fetch", 64'(nfetch >= tgt), 1);
    end
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("abort_mosi", 64'(s_mosi), 0);
    check("abort_res", 64'(s_res), 0);
    check("abort_wr", 64'(s_wr), 0);
    check("abort_busy", 64'(s_busy), 0);
    wait_idle(60);
    check("abort_writes", 64'(nwr - base), 2);

    // Mode 11 with the masked bit already high on entry
    rand_miso = 1'b0; miso_data = 24'h000001;
    cfg_write(1'b0, 24'h000001);
    cfg_write(1'b1, 24'h000001);
    step(); step();
    push(24'h0A0A0A, 8'd8, 2'b11);
    for (int i = 0; i < 4; i++) step();
    miso_data = '0;
    step();
    miso_data = 24'h000001;
    wait_idle(40);
    check("mode3_flags", 64'(last_rec[1:0]), 2'b01);
`ifdef DUT_SEQ_EDGE_TRIG_EN
    check("mode3_edge_late", 64'(last_rec[9:2] != 0), 1);
`else
    check("mode3_immediate", 64'(last_rec[9:2]), 0);
`endif

    // Randomised batches with random configuration and back-pressure
    rand_miso = 1'b1; rand_full = 1'b1;
    for (int b = 0; b < 8; b++) begin
      cfg_write(1'b0, (24'h1 << $urandom_range(0, 23)) | (24'($urandom) & 24'h000007));
      cfg_write(1'b1, 24'($urandom));
      for (int k = 0; k < 5; k++)
        push(24'($urandom), 8'($urandom_range(0, 12)), 2'($urandom_range(0, 3)));
      wait_idle(500);
    end
    rand_full = 1'b0; res_full = 1'b0;
    step(); step();
    check("final_pending", 64'(fq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dut_vector_sequencer.md
# dut_vector_sequencer

Parametrised successor to the existing DUT interface pipeline. It fetches stimulus vectors from a show-ahead stimulus FIFO, drives each onto the DUT inputs, and holds it for a fixed cycle count or until a configurable trigger condition or timeout. It then writes one result record per vector to the result FIFO. It sits between the stimulus/result FIFOs and the DUT pins and adds multiple trigger modes, a programmable trigger value, explicit timeout/match flags, and back-pressure without clock gating.

## Interface
- STF_WIDTH, 24, DUT input (stimulus) width
- RTF_WIDTH, 24, DUT output (response) width
- CYCLE_RANGE, 8, width of the per-vector cycle count and result count
- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- stim_data  in  STF_WIDTH+CYCLE_RANGE+2  {data[STF], cycles[CYCLE_RANGE], mode[1:0]}; show-ahead, valid while ~stim_empty
- stim_empty  in  1  stimulus FIFO empty
- stim_rdreq  out  1  pop one stimulus word
- cfg_valid  in  1  configuration write strobe
- cfg_addr  in  1  0 = trigger mask, 1 = trigger value
- cfg_data  in  RTF_WIDTH  configuration data
- res_data  out  RTF_WIDTH+CYCLE_RANGE+2  {result[RTF], count[CYCLE_RANGE], timeout, matched}
- res_wrreq  out  1  result FIFO write strobe
- res_full  in  1  result FIFO full
- mosi_data  out  STF_WIDTH  DUT stimulus, registered
- miso_data  in  RTF_WIDTH  DUT response, asynchronous to vector timing
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, RUN, WRITE.
- IDLE: if ~stim_empty, assert stim_rdreq combinationally for one cycle, latch data/cycles/mode, load mosi_data with data, clear counter, go RUN. Otherwise stay.
- miso_q: miso_data registered every cycle. All compares use miso_q, never raw miso_data.
- Modes:
  - 00 FIXED: hold for max(cycles,1) RUN cycles. Exit when counter == max(cycles,1)-1. matched=0, timeout=0.
  - 01 TRIG_ALL: match when (miso_q & mask) == (value & mask).
  - 10 TRIG_ANY: match when (miso_q & mask) != 0.
  - 11 EDGE: see Configuration.
- Trigger modes evaluate every RUN cycle. On match, exit with matched=1. Else, when counter == cycles, exit with timeout=1. A match in the timeout cycle reports matched=1, timeout=0. cycles=0 gives a single check.
- Counter is CYCLE_RANGE bits, increments each RUN cycle, and never exceeds cycles, so no wrap.
- On exit: capture result=miso_q and count=counter, go WRITE.
- WRITE: if ~res_full, assert res_wrreq for exactly one cycle and go IDLE. If res_full, hold with res_wrreq=0 and the record stable; mosi_data stays at the current vector.
- mosi_data keeps the last vector until the next vector is fetched.
- Config: cfg_valid writes mask (addr 0) or value (addr 1) in any state. The new value takes effect on the next clock.
- reset: state=IDLE; mosi_data, res_data, mask, value, counter and miso_q = 0; stim_rdreq, res_wrreq and busy = 0. Reset mid-vector aborts it with no result written; the popped word is lost.

## Timing
- stim_rdreq is combinational from state and stim_empty. It is never asserted outside IDLE.
- mosi_data changes on the clock edge ending the IDLE fetch cycle.
- The earliest trigger observation reflects miso_data sampled one cycle after mosi_data changes.
- Per-vector latency with ~res_full: FIXED takes 1 + max(cycles,1) + 1 clocks. A trigger matching in RUN cycle k (0-based) takes k+3 clocks.
- res_wrreq and res_data are registered outputs, asserted for one cycle per vector and never with res_full high.

## Configuration
- DUT_SEQ_EDGE_TRIG_EN defined:
  - mode 11 is EDGE. On RUN entry, prev = miso_q.
  - Match when (miso_q & ~prev & mask) != 0, i.e. a rising edge on any masked bit. prev updates every RUN cycle.
  - Timeout as in the other trigger modes.
- Not defined: mode 11 behaves as TRIG_ALL, and no prev register is built.

## Test plan
- Reset, then FIXED vector data=0xA5A5A5, cycles=3 -> mosi_data=0xA5A5A5 for 3 RUN cycles; one record with count=2, timeout=0, matched=0; vector-to-write latency 5 clocks.
- TRIG_ALL with mask=0x00000F, value=0x000005, cycles=10; miso goes 0x5 after 4 cycles -> matched=1, count reflects the first matching miso_q, timeout=0.
- TRIG_ANY with mask=0x000100, cycles=6, miso stays 0 -> timeout=1, matched=0, count=6; cycles=0 -> single check, count=0, timeout=1.
- res_full held high for 5 cycles in WRITE -> res_wrreq stays 0 and res_data stable; exactly one write after res_full drops; next vector is not fetched before that write.
- Three back-to-back vectors, then reset asserted in RUN of the second -> only the first record is written; all outputs 0 next cycle; the third vector runs normally after reset.
- With DUT_SEQ_EDGE_TRIG_EN: mode 11, mask=0x1, miso already 1 at RUN entry -> no match until a 0->1 transition; without the macro the same stimulus matches immediately as TRIG_ALL with value=1.
